// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter on the data-memory bus.
// TXDATA (+0) stores push bytes into a small circular FIFO, and STATUS (+4)
// reports {ovf, busy, empty, full}. A four-state serializer drains the FIFO
// onto a registered, idle-high tx line. Frames are sent back to back with
// no idle gap between them.
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        sel,
  output logic        tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------
  logic hit;
  logic hit_txdata;
  logic hit_status;

  assign hit        = (a[31:3] == BASE_ADDR[31:3]);
  assign hit_txdata = hit & ~a[2];
  assign hit_status = hit &  a[2];
  assign sel        = hit;

  // The byte offset and the upper store-data bits are don't-care.
  logic unused_bus_bits;
  assign unused_bus_bits = ^{a[1:0], wd[31:8]};

  // ---------------------------------------------------------------------
  // TX FIFO: the extra pointer bit tells full apart from empty
  // ---------------------------------------------------------------------
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic [7:0]    head;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  // Full is judged on the registered pointers, so a push while full is
  // dropped even if the serializer pops in the same cycle.
  assign push  = we & hit_txdata & ~full;
  assign head  = mem_q[rptr_q[AW-1:0]];

  // Storage array: payload only, never reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q[AW-1:0]] <= wd[7:0];
    end
  end

  // Next-state pointer arithmetic
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) begin
      wptr_d = wptr_q + PW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PW'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Sticky overflow flag
  // ---------------------------------------------------------------------
  logic ovf_q, ovf_d;

  // Set on a dropped push and cleared by writing bit 3 of STATUS; the two
  // events target different addresses, so they never coincide.
  always_comb begin
    ovf_d = ovf_q;
    if (we && hit_txdata && full) begin
      ovf_d = 1'b1;
    end else if (we && hit_status && wd[3]) begin
      ovf_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Serializer
  // ---------------------------------------------------------------------
  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          baud_last;
  logic          busy;

  assign baud_last = (baud_q == BAUD_LAST);
  assign busy      = (state_q != S_IDLE);

  // Next-state logic; tx_d is decoded from the state being entered so that
  // the registered line changes on the same edge as the state.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    tx_d    = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          bit_d   = 3'd0;
          baud_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = S_DATA;
        end else begin
          baud_d  = baud_q + CW'(1);
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          baud_d  = baud_q + CW'(1);
        end
      end
      S_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            bit_d   = 3'd0;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d  = baud_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
      end
    endcase

    unique case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // State and control registers, synchronous active-high reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
      wptr_q  <= '0;
      rptr_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      ovf_q   <= ovf_d;
    end
  end

  assign tx = tx_q;

  // ---------------------------------------------------------------------
  // Load data
  // ---------------------------------------------------------------------
  // Only STATUS returns data; TXDATA and misses read as zero.
  always_comb begin
    rd = 32'h0;
    if (hit_status) begin
      rd = {28'h0, ovf_q, busy, empty, full};
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio at CLKS_PER_BIT=4, FIFO_DEPTH=8.
module tb_uart_tx_mmio;

  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam int          CPB  = 4;

  logic        clk;
  logic        reset;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        sel;
  logic        tx;

  int n_cmp;
  int n_fail;
  logic [7:0] rx_q[$];

  uart_tx_mmio #(
    .BASE_ADDR   (BASE),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .we   (we),
    .a    (a),
    .wd   (wd),
    .rd   (rd),
    .sel  (sel),
    .tx   (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic        exp_sel;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    we = 1'b1;
    a  = addr;
    wd = data;
    tick();
    we = 1'b0;
    a  = 32'h0;
    wd = 32'h0;
  endtask

  task automatic load(input logic [31:0] addr, output logic [31:0] v);
    a = addr;
    #1;
    v = rd;
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int i);
    int k;
    k = i / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  // Cycle-exact frame check, entered in the first cycle of the start bit.
  task automatic check_frames(input logic [7:0] b0, input logic [7:0] b1, input int n);
    logic [7:0] cur;
    a = BASE + 32'd4;
    #1;
    for (int f = 0; f < n; f++) begin
      cur = (f == 0) ? b0 : b1;
      for (int i = 0; i < 10 * CPB; i++) begin
        check($sformatf("tx_f%0d_c%0d", f, i), 32'(tx), 32'(frame_bit(cur, i)));
        check($sformatf("busy_f%0d_c%0d", f, i), 32'(rd[2]), 32'd1);
        tick();
      end
    end
    check("tx_idle_after_frames", 32'(tx), 32'd1);
    check("busy_clear_after_frames", 32'(rd[2]), 32'd0);
  endtask

  // Independent line decoder: samples each bit one cycle into its cell.
  initial begin : rx_model
    logic [7:0] b;
    bit         abort;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && tx === 1'b0) begin
        b     = 8'h0;
        abort = 1'b0;
        for (int c = 1; c <= 9 * CPB + 1; c++) begin
          @(negedge clk);
          if (reset === 1'b1) abort = 1'b1;
          if (!abort && c >= CPB + 1 && c <= 8 * CPB + 1 && (c % CPB) == 1)
            b[(c - CPB - 1) / CPB] = tx;
          if (!abort && c == 9 * CPB + 1) begin
            check("rx_stop_bit", 32'(tx), 32'd1);
            rx_q.push_back(b);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] v;
    int          k;
    int          lows;

    n_cmp  = 0;
    n_fail = 0;
    reset  = 1'b1;
    we     = 1'b0;
    a      = 32'h0;
    wd     = 32'h0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    check("reset_tx", 32'(tx), 32'd1);
    load(BASE + 32'd4, v);
    check("reset_status", v, 32'h2);
    check("reset_sel", 32'(sel), 32'd1);

    // Decode and register access table, block idle and empty
    tbl[0]  = '{1'b0, BASE + 32'd0,  32'h0,         1'b1, 32'h0};
    tbl[1]  = '{1'b0, BASE + 32'd4,  32'h0,         1'b1, 32'h2};
    tbl[2]  = '{1'b0, BASE + 32'd5,  32'h0,         1'b1, 32'h2};
    tbl[3]  = '{1'b0, BASE + 32'd7,  32'h0,         1'b1, 32'h2};
    tbl[4]  = '{1'b0, BASE + 32'd8,  32'h0,         1'b0, 32'h0};
    tbl[5]  = '{1'b0, BASE - 32'd4,  32'h0,         1'b0, 32'h0};
    tbl[6]  = '{1'b1, BASE + 32'd8,  32'h33,        1'b0, 32'h0};
    tbl[7]  = '{1'b1, BASE - 32'd4,  32'h44,        1'b0, 32'h0};
    tbl[8]  = '{1'b0, BASE + 32'd4,  32'h0,         1'b1, 32'h2};
    tbl[9]  = '{1'b1, BASE + 32'd4,  32'hFFFF_FFF7, 1'b1, 32'h2};
    tbl[10] = '{1'b0, BASE + 32'd4,  32'h0,         1'b1, 32'h2};
    tbl[11] = '{1'b0, 32'h0,         32'h0,         1'b0, 32'h0};
    tbl[12] = '{1'b0, BASE + 32'd3,  32'h0,         1'b1, 32'h0};

    for (int i = 0; i < 13; i++) begin
      we = tbl[i].we;
      a  = tbl[i].a;
      wd = tbl[i].wd;
      #1;
      check($sformatf("vec%0d_sel", i), 32'(sel), 32'(tbl[i].exp_sel));
      check($sformatf("vec%0d_rd", i), rd, tbl[i].exp_rd);
      check($sformatf("vec%0d_tx", i), 32'(tx), 32'd1);
      tick();
      we = 1'b0;
    end
    a  = 32'h0;
    wd = 32'h0;

    // Single byte 0xA5
    rx_q.delete();
    store(BASE, 32'h0000_00A5);
    load(BASE + 32'd4, v);
    check("a5_status_before_pop", v, 32'h0);
    check("a5_tx_before_pop", 32'(tx), 32'd1);
    tick();
    load(BASE + 32'd4, v);
    check("a5_status_after_pop", v, 32'h6);
    check_frames(8'hA5, 8'h00, 1);
    check("a5_rx_count", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() >= 1) check("a5_rx_byte", 32'(rx_q[0]), 32'hA5);

    // Back-to-back 0x55 then 0xAA
    rx_q.delete();
    store(BASE, 32'h55);
    store(BASE, 32'hAA);
    check_frames(8'h55, 8'hAA, 2);
    check("b2b_rx_count", 32'(rx_q.size()), 32'd2);
    if (rx_q.size() >= 2) begin
      check("b2b_rx0", 32'(rx_q[0]), 32'h55);
      check("b2b_rx1", 32'(rx_q[1]), 32'hAA);
    end

    // Fill: 0x01 pops at the second edge, so 0x02..0x09 fill all 8 slots
    rx_q.delete();
    for (int i = 1; i <= 9; i++) store(BASE, 32'(i));
    load(BASE + 32'd4, v);
    check("fill_status_full", v, 32'h5);
    store(BASE, 32'h0A);
    load(BASE + 32'd4, v);
    check("fill_status_ovf", v, 32'hD);
    store(BASE + 32'd4, 32'h0);
    load(BASE + 32'd4, v);
    check("ovf_kept_on_zero_write", v, 32'hD);
    store(BASE + 32'd4, 32'h8);
    load(BASE + 32'd4, v);
    check("ovf_cleared", v, 32'h5);
    store(BASE, 32'h0B);
    load(BASE + 32'd4, v);
    check("ovf_set_again", v, 32'hD);
    store(BASE + 32'd4, 32'h8);
    load(BASE + 32'd4, v);
    check("ovf_cleared_again", v, 32'h5);

    a = BASE + 32'd4;
    #1;
    k = 0;
    while (k < 600 && rd[2] === 1'b1) begin
      tick();
      k++;
    end
    check("fill_drain_busy", 32'(rd[2]), 32'd0);
    check("fill_drain_status", rd, 32'h2);
    check("fill_rx_count", 32'(rx_q.size()), 32'd9);
    for (int i = 0; i < 9 && i < rx_q.size(); i++)
      check($sformatf("fill_rx%0d", i), 32'(rx_q[i]), 32'(i + 1));

    // Reset during data bit 3 of 0x11 with 0x22, 0x33 queued
    rx_q.delete();
    store(BASE, 32'h11);
    store(BASE, 32'h22);
    store(BASE, 32'h33);
    repeat (16) tick();
    check("mid_tx_bit3", 32'(tx), 32'd0);
    load(BASE + 32'd4, v);
    check("mid_status", v, 32'h4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_reset_tx", 32'(tx), 32'd1);
    load(BASE + 32'd4, v);
    check("mid_reset_status", v, 32'h2);
    lows = 0;
    repeat (100) begin
      if (tx !== 1'b1) lows++;
      tick();
    end
    check("mid_reset_line_quiet", 32'(lows), 32'd0);
    check("mid_reset_rx_count", 32'(rx_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
